// File: rtl/exec_to_wb_lane_if.sv
// Bundle between the fetch-regs stage, one execution lane and the coalesce stage.
// The master drives instructions and pipeline control; the slave is the lane.
interface exec_to_wb_lane_if;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_ins;
    logic [15:0] in_ra_val;
    logic [15:0] in_rx_val;
    logic        stall;
    logic        flush;

    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_ins;
    logic [15:0] out_result;
    logic        out_wen;
    logic [3:0]  out_rt;
    logic        out_taken;
    logic [15:0] out_target;
    logic [15:0] out_mem_addr;
    logic [15:0] out_mem_wdata;
    logic        out_mem_ld;
    logic        out_mem_st;
    logic        out_halt;
    logic [1:0]  out_lane;

    modport master (
        output in_valid, in_pc, in_ins, in_ra_val, in_rx_val, stall, flush,
        input  out_valid, out_pc, out_ins, out_result, out_wen, out_rt, out_taken,
               out_target, out_mem_addr, out_mem_wdata, out_mem_ld, out_mem_st,
               out_halt, out_lane
    );

    modport slave (
        input  in_valid, in_pc, in_ins, in_ra_val, in_rx_val, stall, flush,
        output out_valid, out_pc, out_ins, out_result, out_wen, out_rt, out_taken,
               out_target, out_mem_addr, out_mem_wdata, out_mem_ld, out_mem_st,
               out_halt, out_lane
    );
endinterface

// File: rtl/exec_to_wb_lane.sv
// One vector-CPU execution lane: combinational execute captured into stage X,
// then moved to stage W which drives the coalesce stage (2-cycle latency).
module exec_to_wb_lane #(
    parameter int unsigned LANE_ID = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_to_wb_lane_if.slave     lane
);

    typedef struct packed {
        logic [15:0] result;
        logic        wen;
        logic        taken;
        logic [15:0] target;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        mem_ld;
        logic        mem_st;
        logic        halt;
    } exec_t;

    logic [3:0]  opcode;
    logic [3:0]  subcode;
    logic [15:0] ra;
    logic [15:0] rx;
    exec_t       exec_next;

    logic        x_valid_reg;
    logic [15:0] x_pc_reg;
    logic [15:0] x_ins_reg;
    exec_t       x_exec_reg;
    logic        w_valid_reg;
    logic [15:0] w_pc_reg;
    logic [15:0] w_ins_reg;
    exec_t       w_exec_reg;

    assign opcode  = lane.in_ins[15:12];
    assign subcode = lane.in_ins[7:4];
    assign ra      = lane.in_ra_val;
    assign rx      = lane.in_rx_val;

    always_comb begin
        exec_next = '0;
        case (opcode)
            4'h0, 4'h8: begin
                exec_next.result = ra + rx;
                exec_next.wen    = 1'b1;
            end
            4'h1, 4'h9: begin
                exec_next.result = ra - rx;
                exec_next.wen    = 1'b1;
            end
            4'h2, 4'hA: begin
                exec_next.result = ra * rx;
                exec_next.wen    = 1'b1;
            end
            4'h3, 4'hB: begin
                // Divide-by-zero saturates instead of trapping.
                exec_next.result = (rx == 16'h0000) ? 16'hFFFF : (ra / rx);
                exec_next.wen    = 1'b1;
            end
            4'h4: begin
                exec_next.result = {{8{lane.in_ins[11]}}, lane.in_ins[11:4]};
                exec_next.wen    = 1'b1;
            end
            4'h5: begin
                exec_next.result = {lane.in_ins[11:4], rx[7:0]};
                exec_next.wen    = 1'b1;
            end
            4'h6: begin
                exec_next.target = rx;
                case (subcode)
                    4'h0:    exec_next.taken = (ra == 16'h0000);
                    4'h1:    exec_next.taken = (ra != 16'h0000);
                    4'h2:    exec_next.taken = ra[15];
                    4'h3:    exec_next.taken = ~ra[15];
                    default: exec_next.taken = 1'b0;
                endcase
            end
            4'hC: begin
                // Load result stays 0; coalesce substitutes the returned data.
                exec_next.mem_addr  = ra;
                exec_next.mem_wdata = rx;
                if (subcode == 4'h0) begin
                    exec_next.mem_ld = 1'b1;
                    exec_next.wen    = 1'b1;
                end else if (subcode == 4'h1) begin
                    exec_next.mem_st = 1'b1;
                end
            end
            4'hF: begin
                exec_next.halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_valid_reg <= 1'b0;
            x_pc_reg    <= '0;
            x_ins_reg   <= '0;
            x_exec_reg  <= '0;
            w_valid_reg <= 1'b0;
            w_pc_reg    <= '0;
            w_ins_reg   <= '0;
            w_exec_reg  <= '0;
        end else if (lane.flush) begin
            // Flush wins over stall; data may stay stale behind cleared valids.
            x_valid_reg <= 1'b0;
            w_valid_reg <= 1'b0;
        end else if (!lane.stall) begin
            x_valid_reg <= lane.in_valid;
            x_pc_reg    <= lane.in_pc;
            x_ins_reg   <= lane.in_ins;
            x_exec_reg  <= exec_next;
            w_valid_reg <= x_valid_reg;
            w_pc_reg    <= x_pc_reg;
            w_ins_reg   <= x_ins_reg;
            w_exec_reg  <= x_exec_reg;
        end
    end

    // Flags are qualified by the W valid so a bubble never requests anything.
    assign lane.out_valid     = w_valid_reg;
    assign lane.out_pc        = w_pc_reg;
    assign lane.out_ins       = w_ins_reg;
    assign lane.out_result    = w_exec_reg.result;
    assign lane.out_wen       = w_valid_reg & w_exec_reg.wen;
    assign lane.out_rt        = w_ins_reg[3:0];
    assign lane.out_taken     = w_valid_reg & w_exec_reg.taken;
    assign lane.out_target    = w_exec_reg.target;
    assign lane.out_mem_addr  = w_exec_reg.mem_addr;
    assign lane.out_mem_wdata = w_exec_reg.mem_wdata;
    assign lane.out_mem_ld    = w_valid_reg & w_exec_reg.mem_ld;
    assign lane.out_mem_st    = w_valid_reg & w_exec_reg.mem_st;
    assign lane.out_halt      = w_valid_reg & w_exec_reg.halt;
    assign lane.out_lane      = 2'(LANE_ID);

endmodule

// File: tb/tb_exec_to_wb_lane.sv
// Scoreboard bench for exec_to_wb_lane: the driver pushes reference results,
// a monitor pops and compares each time the lane presents an output.
module tb_exec_to_wb_lane;

    localparam int unsigned LANE = 2;

    typedef enum logic [1:0] {K_RESET, K_FLUSH, K_STALL, K_ADV} kind_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] result;
        logic        wen;
        logic        taken;
        logic [15:0] target;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ld;
        logic        st;
        logic        halt;
        logic        chk_res;
        logic        chk_tgt;
        logic        chk_mem;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] result;
        logic        wen;
        logic [3:0]  rt;
        logic        taken;
        logic [15:0] target;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ld;
        logic        st;
        logic        halt;
        logic [1:0]  lane;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    exec_to_wb_lane_if bif();

    exec_to_wb_lane #(.LANE_ID(LANE)) dut (
        .clk   (clk),
        .reset (reset),
        .lane  (bif.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    kind_e edge_kind = K_RESET;
    bit    exp_valid = 1'b0;
    bit    x_live = 1'b0;
    logic [15:0] pc_ctr = 16'h1000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference behaviour written from the instruction table with plain integer arithmetic.
    function automatic exp_t ref_exec(input logic [15:0] pc, input logic [15:0] ins,
                                      input logic [15:0] ra, input logic [15:0] rx);
        exp_t            e;
        int unsigned     a;
        int unsigned     x;
        int unsigned     imm;
        longint unsigned p;
        a = ra; x = rx; imm = ins[11:4];
        e = '0; e.pc = pc; e.ins = ins; e.chk_res = 1'b1;
        case (ins[15:12])
            4'h0, 4'h8: begin e.result = 16'((a + x) % 65536); e.wen = 1'b1; end
            4'h1, 4'h9: begin e.result = 16'((a + 65536 - x) % 65536); e.wen = 1'b1; end
            4'h2, 4'hA: begin
                p = longint'(a) * longint'(x);
                e.result = 16'(p % 65536); e.wen = 1'b1;
            end
            4'h3, 4'hB: begin e.result = (x == 0) ? 16'hFFFF : 16'(a / x); e.wen = 1'b1; end
            4'h4: begin e.result = 16'((imm >= 128) ? imm + 65280 : imm); e.wen = 1'b1; end
            4'h5: begin e.result = 16'(imm * 256 + x % 256); e.wen = 1'b1; end
            4'h6: begin
                e.chk_tgt = 1'b1; e.target = rx;
                case (ins[7:4])
                    4'h0:    e.taken = (a == 0);
                    4'h1:    e.taken = (a != 0);
                    4'h2:    e.taken = (a >= 32768);
                    4'h3:    e.taken = (a < 32768);
                    default: e.taken = 1'b0;
                endcase
            end
            4'hC: begin
                e.chk_mem = 1'b1; e.addr = ra; e.wdata = rx;
                if (ins[7:4] == 4'h0) begin e.ld = 1'b1; e.wen = 1'b1; end
                else if (ins[7:4] == 4'h1) begin e.st = 1'b1; e.chk_res = 1'b0; end
                else e.chk_res = 1'b0;
            end
            4'hF: begin e.halt = 1'b1; e.chk_res = 1'b0; end
            default: ;
        endcase
        return e;
    endfunction

    // Sets inputs for the next rising edge and records what that edge should do.
    task automatic cyc(input bit r, input bit f, input bit s, input bit v,
                       input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rx);
        reset = r; bif.flush = f; bif.stall = s; bif.in_valid = v;
        bif.in_pc = pc_ctr; bif.in_ins = ins; bif.in_ra_val = ra; bif.in_rx_val = rx;
        if (r || f) begin
            edge_kind = r ? K_RESET : K_FLUSH;
            if (x_live) void'(exp_q.pop_back());
            x_live = 1'b0; exp_valid = 1'b0;
        end else if (s) begin
            edge_kind = K_STALL;
        end else begin
            edge_kind = K_ADV;
            exp_valid = x_live;
            x_live = v;
            if (v) exp_q.push_back(ref_exec(pc_ctr, ins, ra, rx));
        end
        pc_ctr = pc_ctr + 16'd2;
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rx);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, ins, ra, rx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    // Monitor: samples 1 time unit after every rising edge.
    initial begin
        obs_t cur;
        obs_t last;
        exp_t e;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = '{bif.out_valid, bif.out_pc, bif.out_ins, bif.out_result, bif.out_wen,
                    bif.out_rt, bif.out_taken, bif.out_target, bif.out_mem_addr,
                    bif.out_mem_wdata, bif.out_mem_ld, bif.out_mem_st, bif.out_halt,
                    bif.out_lane};
            chk("lane_id", cur.lane, LANE);
            case (edge_kind)
                K_RESET: begin
                    chk("reset_valid", cur.valid, 0);
                    chk("reset_flags", {cur.wen, cur.taken, cur.ld, cur.st, cur.halt}, 0);
                    chk("reset_data", {cur.pc, cur.ins, cur.result}, 0);
                end
                K_FLUSH: begin
                    chk("flush_valid", cur.valid, 0);
                    chk("flush_flags", {cur.wen, cur.taken, cur.ld, cur.st, cur.halt}, 0);
                end
                K_STALL: begin
                    chk("stall_hold", cur, last);
                end
                default: begin
                    chk("out_valid", cur.valid, exp_valid);
                    if (cur.valid && exp_q.size() == 0) begin
                        chk("unexpected_output", cur.pc, 0);
                    end else if (cur.valid) begin
                        e = exp_q.pop_front();
                        chk("pc", cur.pc, e.pc);
                        chk("ins", cur.ins, e.ins);
                        chk("rt", cur.rt, e.ins[3:0]);
                        chk("flags", {cur.wen, cur.taken, cur.ld, cur.st, cur.halt},
                            {e.wen, e.taken, e.ld, e.st, e.halt});
                        if (e.chk_res) chk("result", cur.result, e.result);
                        if (e.chk_tgt) chk("target", cur.target, e.target);
                        if (e.chk_mem) chk("mem", {cur.addr, cur.wdata}, {e.addr, e.wdata});
                        $display("t=%0t out pc=%h ins=%h result=%h", $time, cur.pc, cur.ins, cur.result);
                    end else begin
                        chk("bubble_flags", {cur.wen, cur.taken, cur.ld, cur.st, cur.halt}, 0);
                    end
                end
            endcase
            last = cur;
        end
    end

    initial begin
        logic [3:0]  op;
        logic [3:0]  sub;
        logic [15:0] ins;
        logic [15:0] ra;
        logic [15:0] rx;
        reset = 1'b1; bif.flush = 1'b0; bif.stall = 1'b0; bif.in_valid = 1'b0;
        bif.in_pc = '0; bif.in_ins = '0; bif.in_ra_val = '0; bif.in_rx_val = '0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

        // Single add, then a gap so the 2-edge latency and the bubble are exercised.
        issue(16'h0123, 16'd5, 16'd7);
        idle(3);

        // Arithmetic edges
        issue(16'h1123, 16'd3, 16'd5);
        issue(16'h2123, 16'h0100, 16'h0100);
        issue(16'h3123, 16'd7, 16'd2);
        issue(16'h3123, 16'd9, 16'd0);
        issue(16'h8123, 16'hFFFF, 16'd1);
        // Moves and branches
        issue(16'h4801, 16'h0, 16'h0);
        issue(16'h5122, 16'h0, 16'h0034);
        issue(16'h6100, 16'h0, 16'h0040);
        issue(16'h6110, 16'h0, 16'h0040);
        issue(16'h6120, 16'h8000, 16'h0050);
        // Memory and halt
        issue(16'hC105, 16'h0010, 16'h0);
        issue(16'hC110, 16'h0020, 16'h00AB);
        issue(16'hF000, 16'h0, 16'h0);
        idle(3);

        // Four adds, stall for three cycles with junk on the inputs, then release.
        for (int i = 0; i < 4; i++) issue(16'h0121, 16'(i), 16'd100);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0999, 16'hDEAD, 16'hBEEF);
        idle(3);

        // Flush while stalled.
        issue(16'h0122, 16'd1, 16'd1);
        issue(16'h0122, 16'd2, 16'd2);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0122, 16'd3, 16'd3);
        idle(3);

        // Reset with two instructions in flight.
        issue(16'h0124, 16'd4, 16'd4);
        issue(16'h0124, 16'd5, 16'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        idle(3);

        // Random traffic with occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 15));
            sub = (op == 4'h6) ? 4'($urandom_range(0, 5)) :
                  (op == 4'hC) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            ins = {op, 4'($urandom_range(0, 15)), sub, 4'($urandom_range(0, 15))};
            ra  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rx  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70, ins, ra, rx);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
